// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester I2C bus arbiter.
// Both the arbiter and its testbench import this package.
package i2c_bus_arbiter_pkg;

    localparam int unsigned WDATA_W           = 24;
    localparam int unsigned RDATA_W           = 8;
    localparam logic [7:0]  SLAVE_ADDR_OV7670 = 8'h42;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_END = 3'd2,
        BACKOFF  = 3'd3,
        DONE     = 3'd4
    } arbState_t;

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-input round-robin picker. It remembers the requester served last,
// and that requester loses a tie.
module i2c_arb_rr (
    input  logic iCLK,
    input  logic iRST,
    input  logic iREQ0,
    input  logic iREQ1,
    input  logic iUPDATE,
    input  logic iSERVED,
    output logic oVALID,
    output logic oPICK
);

    logic lastServed;

    // Resetting to 1 makes requester 0 win the first tie.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lastServed <= 1'b1;
        end else if (iUPDATE) begin
            lastServed <= iSERVED;
        end
    end

    always_comb begin
        oVALID = iREQ0 | iREQ1;
        if (iREQ0 && iREQ1) begin
            oPICK = ~lastServed;
        end else begin
            oPICK = iREQ1;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C controller between two requesters. It retries after a NACK,
// aborts an attempt on a tick timeout and reports each result with a done pulse.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_RETRY     = 3,
    parameter int unsigned TIMEOUT_TICKS = 255
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iTICK,
    input  logic               iREQ0,
    input  logic               iREQ1,
    input  logic               iWR0,
    input  logic               iWR1,
    input  logic [WDATA_W-1:0] iWDATA0,
    input  logic [WDATA_W-1:0] iWDATA1,
    output logic               oGNT0,
    output logic               oGNT1,
    output logic               oDONE0,
    output logic               oDONE1,
    output logic               oERR0,
    output logic               oERR1,
    output logic [RDATA_W-1:0] oRDATA,
    output logic               oGO,
    output logic               oWR,
    output logic [WDATA_W-1:0] oWDATA,
    input  logic               iEND,
    input  logic               iACK,
    input  logic [RDATA_W-1:0] iRDATA,
    output logic               oBUSY
);

    localparam int unsigned RETRY_W = $clog2(NUM_RETRY + 2);
    localparam int unsigned TICK_W  = $clog2(TIMEOUT_TICKS + 2);

    arbState_t          state;
    arbState_t          nextState;
    logic               owner;
    logic               pickValid;
    logic               pick;
    logic               errFlag;
    logic [RETRY_W-1:0] retryCnt;
    logic [TICK_W-1:0]  tickCnt;
    logic               timeoutHit;
    logic               retryLeft;
    logic               grantNow;
    logic               enteringDone;
    logic               ackedOk;

    assign timeoutHit   = (32'(tickCnt) + 32'd1) >= TIMEOUT_TICKS;
    assign retryLeft    = 32'(retryCnt) < NUM_RETRY;
    assign grantNow     = (state == IDLE) && iTICK && pickValid;
    assign enteringDone = (nextState == DONE) && (state != DONE);
    assign ackedOk      = (state == WAIT_END) && iEND && !iACK;

    i2c_arb_rr uRr (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iREQ0   (iREQ0),
        .iREQ1   (iREQ1),
        .iUPDATE (state == DONE),
        .iSERVED (owner),
        .oVALID  (pickValid),
        .oPICK   (pick)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A controller finish in WAIT_END takes priority over a timeout on the same tick.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (iTICK && pickValid) nextState = START;
            end
            START: begin
                if (iTICK) begin
                    if (timeoutHit) nextState = DONE;
                    else if (!iEND) nextState = WAIT_END;
                end
            end
            WAIT_END: begin
                if (iTICK) begin
                    if (iEND) nextState = (iACK && retryLeft) ? BACKOFF : DONE;
                    else if (timeoutHit) nextState = DONE;
                end
            end
            BACKOFF: begin
                if (iTICK) nextState = START;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        oGO    = (state == START) || (state == WAIT_END);
        oBUSY  = (state != IDLE);
        oDONE0 = (state == DONE) && !owner;
        oDONE1 = (state == DONE) && owner;
        oERR0  = oDONE0 && errFlag;
        oERR1  = oDONE1 && errFlag;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            owner    <= 1'b0;
            oWR      <= 1'b0;
            oWDATA   <= '0;
            oGNT0    <= 1'b0;
            oGNT1    <= 1'b0;
            retryCnt <= '0;
            tickCnt  <= '0;
            errFlag  <= 1'b0;
            oRDATA   <= '0;
        end else begin
            if (grantNow) begin
                owner    <= pick;
                oWR      <= pick ? iWR1 : iWR0;
                oWDATA   <= pick ? iWDATA1 : iWDATA0;
                oGNT0    <= !pick;
                oGNT1    <= pick;
                retryCnt <= '0;
                tickCnt  <= '0;
                errFlag  <= 1'b0;
            end
            if (iTICK && ((state == START) || (state == WAIT_END))) begin
                tickCnt <= tickCnt + TICK_W'(1);
            end
            // Each retry attempt gets a fresh timeout budget.
            if ((state == WAIT_END) && (nextState == BACKOFF)) begin
                retryCnt <= retryCnt + RETRY_W'(1);
                tickCnt  <= '0;
            end
            if (enteringDone) begin
                errFlag <= !ackedOk;
                if (!oWR) oRDATA <= iRDATA;
            end
            if (state == DONE) begin
                oGNT0 <= 1'b0;
                oGNT1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter. A reactive controller model drives the DUT, a
// plan-based reference predicts each transaction, and a monitor checks results.
module tb_i2c_bus_arbiter;
    import i2c_bus_arbiter_pkg::*;

    localparam int unsigned NUM_RETRY     = 3;
    localparam int unsigned TIMEOUT_TICKS = 8;
    localparam int unsigned BUDGET        = 600;

    typedef struct {
        int unsigned nacks;
        bit          stuck;
        logic [7:0]  rdata;
    } plan_t;

    typedef struct {
        bit          who;
        bit          err;
        bit          wr;
        bit          chkRdata;
        logic [23:0] wdata;
        logic [7:0]  rdata;
        int unsigned attempts;
        int unsigned goTicks;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iTICK = 1'b0;
    logic        iREQ0 = 1'b0, iREQ1 = 1'b0, iWR0 = 1'b0, iWR1 = 1'b0;
    logic [23:0] iWDATA0 = '0, iWDATA1 = '0;
    logic        oGNT0, oGNT1, oDONE0, oDONE1, oERR0, oERR1;
    logic [7:0]  oRDATA;
    logic        oGO, oWR, oBUSY;
    logic [23:0] oWDATA;
    logic        iEND = 1'b1, iACK = 1'b1;
    logic [7:0]  iRDATA = '0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    exp_t        expQ[$];
    plan_t       plan[2];
    bit          lastServed = 1'b1;

    i2c_bus_arbiter #(.NUM_RETRY(NUM_RETRY), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK),
        .iREQ0(iREQ0), .iREQ1(iREQ1), .iWR0(iWR0), .iWR1(iWR1),
        .iWDATA0(iWDATA0), .iWDATA1(iWDATA1),
        .oGNT0(oGNT0), .oGNT1(oGNT1), .oDONE0(oDONE0), .oDONE1(oDONE1),
        .oERR0(oERR0), .oERR1(oERR1), .oRDATA(oRDATA),
        .oGO(oGO), .oWR(oWR), .oWDATA(oWDATA),
        .iEND(iEND), .iACK(iACK), .iRDATA(iRDATA), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    initial begin : tickGen
        forever begin
            repeat ($urandom_range(1, 4)) @(posedge iCLK);
            #1 iTICK = 1'b1;
            @(posedge iCLK);
            #1 iTICK = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference: the outcome of a transaction follows directly from the plan the controller obeys.
    function automatic exp_t predict(input bit who, input bit wr, input logic [23:0] wd, input plan_t p);
        exp_t e;
        e.who      = who;
        e.wr       = wr;
        e.wdata    = wd;
        e.rdata    = p.rdata;
        e.err      = p.stuck || (p.nacks > NUM_RETRY);
        e.attempts = p.stuck ? 1 : (((p.nacks > NUM_RETRY) ? NUM_RETRY : p.nacks) + 1);
        e.chkRdata = !wr && !p.stuck;
        e.goTicks  = p.stuck ? TIMEOUT_TICKS : 0;
        return e;
    endfunction

    // Controller model: it accepts on a GO tick, stays busy 1-2 ticks, then NACKs the first plan.nacks attempts.
    initial begin : ctrl
        int unsigned busy, attempt, phase;
        bit tk, go, dn, g1, rst, who;
        busy = 0; attempt = 0; phase = 0; who = 1'b0;
        forever begin
            @(negedge iCLK);
            tk = iTICK; go = oGO; dn = oDONE0 | oDONE1; g1 = oGNT1; rst = iRST;
            @(posedge iCLK);
            #1;
            if (rst) begin
                phase = 0; attempt = 0; iEND = 1'b1; iACK = 1'b1;
            end else begin
                if (dn) attempt = 0;
                case (phase)
                    0: if (tk && go && !plan[g1].stuck) begin
                        who = g1; iEND = 1'b0; busy = $urandom_range(1, 2); phase = 1;
                    end
                    1: if (tk) begin
                        busy--;
                        if (busy == 0) begin
                            iEND = 1'b1;
                            iACK = (attempt < plan[who].nacks);
                            iRDATA = plan[who].rdata;
                            attempt++;
                            phase = 2;
                        end
                    end
                    default: if (!go) phase = 0;
                endcase
            end
        end
    end

    initial begin : monitor
        int unsigned goRises, idleTicks, goTicks;
        bit prevGo, wdOk;
        exp_t e;
        goRises = 0; idleTicks = 0; goTicks = 0; prevGo = 1'b0; wdOk = 1'b1;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                goRises = 0; idleTicks = 0; goTicks = 0; prevGo = 1'b0; wdOk = 1'b1;
            end else begin
                if (iTICK) check("gnt_exclusive", 32'(oGNT0 & oGNT1), 32'd0);
                if (oGO && !prevGo) goRises++;
                prevGo = oGO;
                if (iTICK && oGO) goTicks++;
                if (iTICK && oBUSY && !oGO) idleTicks++;
                if ((oGNT0 || oGNT1) && (expQ.size() > 0)) begin
                    if ((oWDATA !== expQ[0].wdata) || (oWR !== expQ[0].wr)) wdOk = 1'b0;
                end
                if (oDONE0 || oDONE1) begin
                    if (expQ.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: oDONE0=%0b oDONE1=%0b, expected no done", oDONE0, oDONE1);
                    end else begin
                        e = expQ.pop_front();
                        check("done_owner", 32'(oDONE1), 32'(e.who));
                        check("done_single", 32'(oDONE0 & oDONE1), 32'd0);
                        check("gnt_at_done", 32'(e.who ? oGNT1 : oGNT0), 32'd1);
                        check("err", 32'(e.who ? oERR1 : oERR0), 32'(e.err));
                        check("err_other", 32'(e.who ? oERR0 : oERR1), 32'd0);
                        check("wdata", 32'(oWDATA), 32'(e.wdata));
                        check("wr", 32'(oWR), 32'(e.wr));
                        check("wdata_stable", 32'(wdOk), 32'd1);
                        check("attempts", goRises, e.attempts);
                        check("backoff_ticks", idleTicks, e.attempts - 1);
                        if (e.goTicks != 0) check("timeout_ticks", goTicks, e.goTicks);
                        if (e.chkRdata) check("rdata", 32'(oRDATA), 32'(e.rdata));
                    end
                    goRises = 0; idleTicks = 0; goTicks = 0; wdOk = 1'b1;
                end
            end
        end
    end

    task automatic waitFor(input bit who, input bit wantDone, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge iCLK);
            if (wantDone ? (who ? oDONE1 : oDONE0) : (who ? oGNT1 : oGNT0)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_%s%0d: no response after %0d cycles, expected one", wantDone ? "done" : "gnt", who, BUDGET);
        end
    endtask

    task automatic runOne(input bit who, input bit wr, input logic [23:0] wd, input plan_t p,
                          input bit dropEarly, input bit scramble);
        bit ok;
        plan[who] = p;
        expQ.push_back(predict(who, wr, wd, p));
        lastServed = who;
        @(posedge iCLK);
        #1;
        if (who) begin iWR1 = wr; iWDATA1 = wd; iREQ1 = 1'b1; end
        else     begin iWR0 = wr; iWDATA0 = wd; iREQ0 = 1'b1; end
        waitFor(who, 1'b0, ok);
        if (ok) begin
            if (scramble) begin
                if (who) begin iWDATA1 = 24'($urandom); iWR1 = ~wr; end
                else     begin iWDATA0 = 24'($urandom); iWR0 = ~wr; end
            end
            if (dropEarly) begin
                if (who) iREQ1 = 1'b0; else iREQ0 = 1'b0;
            end
            waitFor(who, 1'b1, ok);
        end
        iREQ0 = 1'b0; iREQ1 = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge iCLK);
    endtask

    task automatic runContention(input int unsigned n);
        plan_t p0, p1;
        logic [23:0] d0, d1;
        bit w0, w1, first, w, ok;
        int unsigned seen;
        p0.nacks = $urandom_range(0, 1); p0.stuck = 1'b0; p0.rdata = 8'($urandom);
        p1.nacks = $urandom_range(0, 1); p1.stuck = 1'b0; p1.rdata = 8'($urandom);
        d0 = 24'($urandom); d1 = 24'($urandom);
        w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
        plan[0] = p0; plan[1] = p1;
        first = ~lastServed;
        for (int unsigned k = 0; k < n; k++) begin
            w = first ^ k[0];
            expQ.push_back(w ? predict(1'b1, w1, d1, p1) : predict(1'b0, w0, d0, p0));
            lastServed = w;
        end
        @(posedge iCLK);
        #1;
        iWR0 = w0; iWDATA0 = d0; iWR1 = w1; iWDATA1 = d1;
        iREQ0 = 1'b1; iREQ1 = 1'b1;
        seen = 0; ok = 1'b1;
        while ((seen < n) && ok) begin
            ok = 1'b0;
            for (int i = 0; i < BUDGET; i++) begin
                @(negedge iCLK);
                if (oDONE0 || oDONE1) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                tests++; fails++;
                $display("FAIL contention_wait: no done after %0d cycles, expected done %0d of %0d", BUDGET, seen + 1, n);
            end
            seen++;
        end
        iREQ0 = 1'b0; iREQ1 = 1'b0;
        repeat (4) @(posedge iCLK);
    endtask

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : stim
        plan_t p;
        bit ok;
        int unsigned dn;
        p.nacks = 0; p.stuck = 1'b0; p.rdata = '0;
        plan[0] = p; plan[1] = p;

        repeat (3) @(negedge iCLK);
        check("rst_go", 32'(oGO), 32'd0);
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_gnt", 32'({oGNT1, oGNT0}), 32'd0);
        check("rst_done", 32'({oDONE1, oDONE0, oERR1, oERR0}), 32'd0);
        check("rst_wdata", 32'({oWR, oWDATA}), 32'd0);
        check("rst_rdata", 32'(oRDATA), 32'd0);
        iRST = 1'b0;
        repeat (3) @(negedge iCLK);

        p.nacks = 0; p.stuck = 1'b0; p.rdata = 8'h00;
        runOne(1'b0, 1'b1, {SLAVE_ADDR_OV7670, 16'h1280}, p, 1'b0, 1'b0);
        p.rdata = 8'h76;
        runOne(1'b1, 1'b0, 24'h420a00, p, 1'b0, 1'b0);
        p.nacks = 9;
        runOne(1'b1, 1'b1, 24'h421111, p, 1'b0, 1'b0);
        p.nacks = NUM_RETRY;
        runOne(1'b0, 1'b0, 24'h423344, p, 1'b0, 1'b1);
        p.nacks = NUM_RETRY + 1;
        runOne(1'b0, 1'b1, 24'h425566, p, 1'b1, 1'b0);
        p.nacks = 0; p.stuck = 1'b1;
        runOne(1'b0, 1'b1, 24'h427788, p, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            p.nacks = $urandom_range(0, 5);
            p.stuck = ($urandom_range(0, 7) == 0);
            p.rdata = 8'($urandom);
            runOne(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), p,
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        runContention(4);

        p.nacks = 0; p.stuck = 1'b1; p.rdata = '0;
        plan[0] = p;
        @(posedge iCLK);
        #1;
        iWR0 = 1'b1; iWDATA0 = 24'habcdef; iREQ0 = 1'b1;
        waitFor(1'b0, 1'b0, ok);
        repeat (6) @(negedge iCLK);
        check("midrst_inflight_go", 32'(oGO), 32'd1);
        #2 iRST = 1'b1;
        #1;
        check("midrst_go", 32'(oGO), 32'd0);
        check("midrst_gnt", 32'({oGNT1, oGNT0}), 32'd0);
        check("midrst_busy", 32'(oBUSY), 32'd0);
        check("midrst_wdata", 32'({oWR, oWDATA}), 32'd0);
        dn = 0;
        repeat (8) begin
            @(negedge iCLK);
            if (oDONE0 || oDONE1) dn++;
        end
        iREQ0 = 1'b0;
        iRST = 1'b0;
        lastServed = 1'b1;
        repeat (20) begin
            @(negedge iCLK);
            if (oDONE0 || oDONE1) dn++;
        end
        check("midrst_no_done", dn, 32'd0);

        runContention(2);

        repeat (20) @(negedge iCLK);
        check("queue_drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
